// File: rtl/riscv_dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory unit.
interface riscv_dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_dmem_unit.sv
// RV32 data-memory unit: byte/half/word little-endian loads and stores with
// extension, misalignment/range checking and a fixed number of wait states.
// Storage is four byte-wide lanes indexed by addr[ADDR_W-1:2].
module riscv_dmem_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  riscv_dmem_if.slave  bus
);
  // ADDR_W == 2 still gets a 1-bit index; the extra bit is out of range and flagged as an error.
  localparam int         IDX_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int         DEPTH     = 2 ** IDX_W;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_ready;
  logic        w_accept;
  logic        w_commit;
  logic        w_c_we;
  logic        w_c_unsigned;
  logic [1:0]  w_c_size;
  logic [31:0] w_c_addr;
  logic [31:0] w_c_wdata;
  logic [1:0]  w_off;
  logic [IDX_W-1:0] w_idx;
  logic        w_err;
  logic [31:0] w_rd_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_ready  = (r_state != WAIT) && !rst;
  assign w_accept = bus.req_valid && w_ready;
  // Commit on the edge that enters RESP: end of WAIT, or the accept edge itself with no wait states.
  assign w_commit = ((r_state == WAIT) && (r_cnt == 4'd0)) || (ZERO_WAIT && w_accept);

  // Commit operands: latched copy while waiting, live request when committing on the accept edge.
  always_comb begin
    w_c_we       = bus.req_we;
    w_c_unsigned = bus.req_unsigned;
    w_c_size     = bus.req_size;
    w_c_addr     = bus.req_addr;
    w_c_wdata    = bus.req_wdata;
    if (r_state == WAIT) begin
      w_c_we       = r_we;
      w_c_unsigned = r_unsigned;
      w_c_size     = r_size;
      w_c_addr     = r_addr;
      w_c_wdata    = r_wdata;
    end
  end

  assign w_off = w_c_addr[1:0];
  assign w_idx = w_c_addr[IDX_W+1:2];

  // Reject misaligned, illegal-size and out-of-range accesses.
  always_comb begin
    w_err = 1'b0;
    case (w_c_size)
      2'b01:   w_err = w_off[0];
      2'b10:   w_err = (w_off != 2'd0);
      2'b11:   w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
    if ((w_c_addr >> ADDR_W) != 32'd0) w_err = 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic [7:0] r_mem [DEPTH];
    logic       w_we;
    logic [7:0] w_wd;

    // Lane enable and right-aligned store data steering for this byte lane.
    always_comb begin
      w_we = 1'b0;
      w_wd = w_c_wdata[7:0];
      case (w_c_size)
        2'b00: w_we = (w_off == LANE);
        2'b01: begin
          w_we = (w_off[1] == LANE[1]);
          w_wd = LANE[0] ? w_c_wdata[15:8] : w_c_wdata[7:0];
        end
        2'b10: begin
          w_we = 1'b1;
          w_wd = w_c_wdata[8*gi +: 8];
        end
        default: w_we = 1'b0;
      endcase
      w_we = w_we && w_commit && w_c_we && !w_err;
    end

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_idx] <= w_wd;
    end

    assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
  end

  assign w_byte = w_rd_word[{w_off, 3'b000} +: 8];
  assign w_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  // Load extension; word loads pass through unchanged.
  always_comb begin
    case (w_c_size)
      2'b00:   w_ext = w_c_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = w_c_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = w_rd_word;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; RESP may accept a new request directly.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) w_state_next = ZERO_WAIT ? RESP : WAIT;
        else          w_state_next = IDLE;
      end
      WAIT:    if (r_cnt == 4'd0) w_state_next = RESP;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_cnt      <= CNT_INIT;
      r_we       <= bus.req_we;
      r_unsigned <= bus.req_unsigned;
      r_size     <= bus.req_size;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response registers, loaded on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else if (w_commit) begin
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (w_err || w_c_we) ? 32'd0 : w_ext;
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_riscv_dmem_unit.sv
// Directed bench: three instances (0, 3 and 2 wait states) on one clock.
module tb_riscv_dmem_unit;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst3 = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_if if0();
  riscv_dmem_if if3();
  riscv_dmem_if if2();

  riscv_dmem_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst0), .bus(if0));
  riscv_dmem_unit #(.ADDR_W(8), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst3), .bus(if3));
  riscv_dmem_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rst(rst2), .bus(if2));

  task automatic drive(input int sel, input logic v, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    case (sel)
      0: begin
        if0.req_valid = v; if0.req_we = we; if0.req_size = size;
        if0.req_unsigned = uns; if0.req_addr = addr; if0.req_wdata = wdata;
      end
      3: begin
        if3.req_valid = v; if3.req_we = we; if3.req_size = size;
        if3.req_unsigned = uns; if3.req_addr = addr; if3.req_wdata = wdata;
      end
      default: begin
        if2.req_valid = v; if2.req_we = we; if2.req_size = size;
        if2.req_unsigned = uns; if2.req_addr = addr; if2.req_wdata = wdata;
      end
    endcase
  endtask

  task automatic get(input int sel, output logic rdy, output logic vld,
                     output logic [31:0] rdata, output logic err);
    case (sel)
      0:       begin rdy = if0.req_ready; vld = if0.rsp_valid; rdata = if0.rsp_rdata; err = if0.rsp_err; end
      3:       begin rdy = if3.req_ready; vld = if3.rsp_valid; rdata = if3.rsp_rdata; err = if3.rsp_err; end
      default: begin rdy = if2.req_ready; vld = if2.rsp_valid; rdata = if2.rsp_rdata; err = if2.rsp_err; end
    endcase
  endtask

  // Single transaction; lat = cycles from accept to rsp_valid (99 if none within the bound).
  task automatic xact(input int sel, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output logic [31:0] rdata, output logic err);
    logic rdy, vld;
    int   n;
    drive(sel, 1'b1, we, size, uns, addr, wdata);
    get(sel, rdy, vld, rdata, err);
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk); #1;
      get(sel, rdy, vld, rdata, err);
      n++;
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, we, size, uns, addr, wdata);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      get(sel, rdy, vld, rdata, err);
      if (vld) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    drive(3, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    drive(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if0.req_ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", if0.req_ready); errors++; end
    checks++; if (if0.rsp_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", if0.rsp_valid); errors++; end
    checks++; if (if0.rsp_rdata !== 32'd0) begin $display("FAIL reset_rdata got %h want 0", if0.rsp_rdata); errors++; end
    checks++; if (if3.req_ready !== 1'b0) begin $display("FAIL reset_ready_w3 got %b want 0", if3.req_ready); errors++; end
    drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
    #1;
    checks++; if (if0.req_ready !== 1'b1) begin $display("FAIL release_ready got %b want 1", if0.req_ready); errors++; end
    checks++; if (if2.req_ready !== 1'b1) begin $display("FAIL release_ready_w2 got %b want 1", if2.req_ready); errors++; end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    logic        we_t   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  size_t [5] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
    logic        uns_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] addr_t [5] = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h10};
    logic [31:0] exp_t  [5] = '{32'h0, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h8899AABB};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, we_t[i], size_t[i], uns_t[i], addr_t[i], 32'h8899AABB);
      checks++; if (if0.req_ready !== 1'b1) begin $display("FAIL b2b_ready[%0d] got %b want 1", i, if0.req_ready); errors++; end
      @(posedge clk); #1;
      checks++; if (if0.rsp_valid !== 1'b1) begin $display("FAIL b2b_valid[%0d] got %b want 1", i, if0.rsp_valid); errors++; end
      checks++; if (if0.rsp_rdata !== exp_t[i]) begin $display("FAIL b2b_rdata[%0d] got %h want %h", i, if0.rsp_rdata, exp_t[i]); errors++; end
      checks++; if (if0.rsp_err !== 1'b0) begin $display("FAIL b2b_err[%0d] got %b want 0", i, if0.rsp_err); errors++; end
      $display("b2b op %0d rdata %h", i, if0.rsp_rdata);
    end
    drive(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (if0.rsp_valid !== 1'b0) begin $display("FAIL b2b_idle_valid got %b want 0", if0.rsp_valid); errors++; end
  endtask

  task automatic test_wait_states();
    int          lat;
    logic [31:0] rd;
    logic        er;
    xact(3, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, lat, rd, er);
    checks++; if (lat !== 4) begin $display("FAIL w3_store_latency got %0d want 4", lat); errors++; end
    drive(3, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (if3.req_ready !== 1'b1) begin $display("FAIL w3_ready_resp got %b want 1", if3.req_ready); errors++; end
    @(posedge clk); #1;
    drive(3, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (if3.req_ready !== 1'b0) begin $display("FAIL w3_ready_wait[%0d] got %b want 0", k, if3.req_ready); errors++; end
      checks++; if (if3.rsp_valid !== 1'b0) begin $display("FAIL w3_valid_wait[%0d] got %b want 0", k, if3.rsp_valid); errors++; end
      @(posedge clk); #1;
    end
    checks++; if (if3.rsp_valid !== 1'b1) begin $display("FAIL w3_lw_valid got %b want 1", if3.rsp_valid); errors++; end
    checks++; if (if3.rsp_rdata !== 32'hCAFEF00D) begin $display("FAIL w3_lw_rdata got %h want cafef00d", if3.rsp_rdata); errors++; end
    checks++; if (if3.req_ready !== 1'b1) begin $display("FAIL w3_ready_in_resp got %b want 1", if3.req_ready); errors++; end
    $display("w3 lw rdata %h", if3.rsp_rdata);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++; if (if3.req_ready !== 1'b0) begin $display("FAIL w3_second_accepted got ready %b want 0", if3.req_ready); errors++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (if3.rsp_valid !== 1'b0) begin $display("FAIL w3_second_early got %b want 0", if3.rsp_valid); errors++; end
    @(posedge clk); #1;
    checks++; if (if3.rsp_valid !== 1'b1) begin $display("FAIL w3_second_valid got %b want 1", if3.rsp_valid); errors++; end
    checks++; if (if3.rsp_rdata !== 32'h000000CA) begin $display("FAIL w3_second_rdata got %h want 000000ca", if3.rsp_rdata); errors++; end
    $display("w3 lbu rdata %h", if3.rsp_rdata);
  endtask

  task automatic test_errors();
    logic        we_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0]  size_t [6] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] addr_t [6] = '{32'h20, 32'h13, 32'h22, 32'h20, 32'h100, 32'h120};
    logic [31:0] wd_t   [6] = '{32'h11223344, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    logic        err_t  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int          lat;
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < 6; i++) begin
      xact(0, we_t[i], size_t[i], 1'b0, addr_t[i], wd_t[i], lat, rd, er);
      checks++; if (er !== err_t[i]) begin $display("FAIL err_flag[%0d] got %b want %b", i, er, err_t[i]); errors++; end
      checks++; if (rd !== 32'd0) begin $display("FAIL err_rdata[%0d] got %h want 0", i, rd); errors++; end
      checks++; if (lat !== 1) begin $display("FAIL err_latency[%0d] got %0d want 1", i, lat); errors++; end
      $display("err op %0d err %b rdata %h", i, er, rd);
    end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h11223344) begin $display("FAIL err_mem_unchanged got %h want 11223344", rd); errors++; end
    checks++; if (er !== 1'b0) begin $display("FAIL err_followup_flag got %b want 0", er); errors++; end
    $display("err followup rdata %h", rd);
  endtask

  task automatic test_byte_lanes();
    int          lat;
    logic [31:0] rd;
    logic        er;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h00000000, lat, rd, er);
    xact(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFF5A, lat, rd, er);
    xact(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hABCD1234, lat, rd, er);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h12345A00) begin $display("FAIL lanes_word got %h want 12345a00", rd); errors++; end
    $display("lanes lw rdata %h", rd);
    xact(0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00001234) begin $display("FAIL lanes_lhu got %h want 00001234", rd); errors++; end
    xact(0, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h0000005A) begin $display("FAIL lanes_lb got %h want 0000005a", rd); errors++; end
    $display("lanes lb rdata %h", rd);
  endtask

  task automatic test_reset_mid_op();
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        seen;
    xact(2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, lat, rd, er);
    checks++; if (lat !== 3) begin $display("FAIL w2_latency got %0d want 3", lat); errors++; end
    drive(2, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    rst2 = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (if2.rsp_valid === 1'b1) seen = 1'b1;
    end
    rst2 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (if2.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin $display("FAIL midreset_response got %b want 0", seen); errors++; end
    xact(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h01020304) begin $display("FAIL midreset_mem got %h want 01020304", rd); errors++; end
    checks++; if (lat !== 3) begin $display("FAIL midreset_latency got %0d want 3", lat); errors++; end
    $display("midreset lw rdata %h", rd);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_byte_lanes();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
